pc_fetch_ctrl: RTL and testbench

Fetch-stage controller that sits directly downstream of the PC mux. It drives the mux `selection`/`enable` inputs, and it holds the architectural PC register that captures the mux output. It computes the sequential next address fed back to the mux and runs the instruction-memory request/acknowledge handshake. It delivers fetched instructions to decode, with branch redirection and optional interrupt entry.

---
 rtl/pc_fetch_ctrl.sv | 146 ++++++++++++++
 tb/tb_pc_fetch_ctrl.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_ctrl.sv
// Fetch-stage controller: drives the PC mux, holds the PC register and runs the imem handshake.
// Optional interrupt entry is compiled in when PC_FETCH_INTR_EN is defined.
module pc_fetch_ctrl #(
    parameter logic [31:0] PC_INC   = 32'd1,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_in,
    output logic [1:0]  pc_sel,
    output logic        pc_en,
    output logic [31:0] pc_q,
    output logic [31:0] next_addr,
    input  logic        branch_taken,
    input  logic        stall,
    input  logic        intr_req,
    output logic        intr_ack,
    output logic [31:0] epc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr_out,
    output logic [31:0] instr_pc
);

    typedef enum logic [1:0] {
        S_BOOT,
        S_IDLE,
        S_WAIT
    } state_t;

    typedef enum logic [1:0] {
        SEL_INTR   = 2'b00,
        SEL_FIRST  = 2'b01,
        SEL_NEXT   = 2'b10,
        SEL_BRANCH = 2'b11
    } sel_t;

    state_t state_q, state_d;
    sel_t   sel_c;
    logic   kill_q, kill_d;
    logic   issue;
    logic   deliver;
    logic   intr_fire;
    logic   intr_take;

`ifdef PC_FETCH_INTR_EN
    assign intr_take = intr_req;
`else
    logic unused_intr_req;
    assign unused_intr_req = intr_req;
    assign intr_take       = 1'b0;
`endif

    assign next_addr = pc_q + PC_INC;
    assign pc_sel    = sel_c;

    always_comb begin
        state_d   = state_q;
        kill_d    = kill_q;
        sel_c     = SEL_NEXT;
        pc_en     = 1'b0;
        issue     = 1'b0;
        deliver   = 1'b0;
        intr_fire = 1'b0;
        case (state_q)
            S_BOOT: begin
                sel_c   = SEL_FIRST;
                pc_en   = 1'b1;
                state_d = S_IDLE;
            end
            S_IDLE: begin
                if (branch_taken) begin
                    sel_c = SEL_BRANCH;
                    pc_en = 1'b1;
                end else if (intr_take) begin
                    sel_c     = SEL_INTR;
                    pc_en     = 1'b1;
                    intr_fire = 1'b1;
                end else if (!stall) begin
                    issue   = 1'b1;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                // A same-cycle branch outranks delivery and any earlier kill.
                if (imem_ack) begin
                    state_d = S_IDLE;
                    kill_d  = 1'b0;
                    if (branch_taken) begin
                        sel_c = SEL_BRANCH;
                        pc_en = 1'b1;
                    end else if (!kill_q) begin
                        sel_c   = SEL_NEXT;
                        pc_en   = 1'b1;
                        deliver = 1'b1;
                    end
                end else if (branch_taken) begin
                    sel_c  = SEL_BRANCH;
                    pc_en  = 1'b1;
                    kill_d = 1'b1;
                end
            end
            default: state_d = S_BOOT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_BOOT;
            kill_q      <= 1'b0;
            pc_q        <= RESET_PC;
            epc         <= '0;
            imem_req    <= 1'b0;
            imem_addr   <= '0;
            instr_valid <= 1'b0;
            instr_out   <= '0;
            instr_pc    <= '0;
            intr_ack    <= 1'b0;
        end else begin
            state_q     <= state_d;
            kill_q      <= kill_d;
            instr_valid <= deliver;
            intr_ack    <= intr_fire;
            if (pc_en) begin
                pc_q <= pc_in;
            end
            if (intr_fire) begin
                epc <= pc_q;
            end
            if (issue) begin
                imem_req  <= 1'b1;
                imem_addr <= pc_q;
            end else if (state_q == S_WAIT && imem_ack) begin
                imem_req <= 1'b0;
            end
            if (deliver) begin
                instr_out <= imem_rdata;
                instr_pc  <= imem_addr;
            end
        end
    end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Bench for pc_fetch_ctrl: directed vector table, corner-case sequences and random stimulus
// checked against a transaction-level model of the fetch controller.
module tb_pc_fetch_ctrl;

    localparam logic [31:0] PC_INC    = 32'd1;
    localparam logic [31:0] RESET_PC  = 32'h0;
    localparam logic [31:0] BOOT_ADDR = 32'h100;
    localparam logic [31:0] VEC_ADDR  = 32'h80;
`ifdef PC_FETCH_INTR_EN
    localparam bit INTR_EN = 1'b1;
`else
    localparam bit INTR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pc_in;
    logic [1:0]  pc_sel;
    logic        pc_en;
    logic [31:0] pc_q;
    logic [31:0] next_addr;
    logic        branch_taken = 1'b0;
    logic        stall = 1'b0;
    logic        intr_req = 1'b0;
    logic        intr_ack;
    logic [31:0] epc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        instr_valid;
    logic [31:0] instr_out;
    logic [31:0] instr_pc;
    logic [31:0] br_target = '0;

    pc_fetch_ctrl #(.PC_INC(PC_INC), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst(rst), .pc_in(pc_in), .pc_sel(pc_sel), .pc_en(pc_en),
        .pc_q(pc_q), .next_addr(next_addr), .branch_taken(branch_taken),
        .stall(stall), .intr_req(intr_req), .intr_ack(intr_ack), .epc(epc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .instr_valid(instr_valid),
        .instr_out(instr_out), .instr_pc(instr_pc)
    );

    always #5 clk = ~clk;

    // PC mux sitting upstream of the controller
    always_comb begin
        case (pc_sel)
            2'b00:   pc_in = VEC_ADDR;
            2'b01:   pc_in = BOOT_ADDR;
            2'b10:   pc_in = next_addr;
            default: pc_in = br_target;
        endcase
    end

    int errors = 0;
    int checks = 0;

    // Model: booted flag, one outstanding fetch with a "discard" mark, plus expected registers.
    bit          m_booted, m_out, m_drop, m_req, m_valid, m_iack;
    logic [31:0] m_pc, m_addr, m_instr, m_ipc, m_epc;
    logic [1:0]  s_sel;
    logic        s_en;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cycle();
        bit          e_en;
        logic [1:0]  e_sel;
        logic [31:0] tgt;
        @(negedge clk);
        s_sel = pc_sel;
        s_en  = pc_en;
        e_en  = 1'b0;
        e_sel = 2'b10;
        if (!m_booted) begin
            e_en = 1'b1; e_sel = 2'b01;
        end else if (!m_out) begin
            if (branch_taken) begin
                e_en = 1'b1; e_sel = 2'b11;
            end else if (INTR_EN && intr_req) begin
                e_en = 1'b1; e_sel = 2'b00;
            end
        end else if (branch_taken) begin
            e_en = 1'b1; e_sel = 2'b11;
        end else if (imem_ack && !m_drop) begin
            e_en = 1'b1; e_sel = 2'b10;
        end
        if (!rst) begin
            chk("pc_en", pc_en, e_en);
            if (e_en) chk("pc_sel", pc_sel, e_sel);
        end
        if (rst) begin
            m_booted = 0; m_out = 0; m_drop = 0; m_req = 0; m_valid = 0; m_iack = 0;
            m_pc = RESET_PC; m_addr = '0; m_instr = '0; m_ipc = '0; m_epc = '0;
        end else begin
            case (e_sel)
                2'b00:   tgt = VEC_ADDR;
                2'b01:   tgt = BOOT_ADDR;
                2'b10:   tgt = m_pc + PC_INC;
                default: tgt = br_target;
            endcase
            m_valid = 0;
            m_iack  = 0;
            if (!m_booted) begin
                m_booted = 1;
            end else if (!m_out) begin
                if (!branch_taken) begin
                    if (INTR_EN && intr_req) begin
                        m_iack = 1; m_epc = m_pc;
                    end else if (!stall) begin
                        m_req = 1; m_addr = m_pc; m_out = 1;
                    end
                end
            end else if (imem_ack) begin
                if (!branch_taken && !m_drop) begin
                    m_valid = 1; m_instr = imem_rdata; m_ipc = m_addr;
                end
                m_req = 0; m_out = 0; m_drop = 0;
            end else if (branch_taken) begin
                m_drop = 1;
            end
            if (e_en) m_pc = tgt;
        end
        @(posedge clk);
        #1;
        chk("pc_q", pc_q, m_pc);
        chk("next_addr", next_addr, m_pc + PC_INC);
        chk("imem_req", imem_req, m_req);
        chk("imem_addr", imem_addr, m_addr);
        chk("instr_valid", instr_valid, m_valid);
        chk("instr_out", instr_out, m_instr);
        chk("instr_pc", instr_pc, m_ipc);
        chk("intr_ack", intr_ack, m_iack);
        chk("epc", epc, m_epc);
    endtask

    typedef struct {
        bit          rst;
        bit          ack;
        logic [31:0] rdata;
        bit          e_en;
        logic [1:0]  e_sel;
        logic [31:0] e_pc;
        bit          e_req;
        logic [31:0] e_addr;
        bit          e_valid;
        logic [31:0] e_instr;
        logic [31:0] e_ipc;
    } vec_t;

    vec_t        tbl [9];
    logic [31:0] p0;

    initial begin
        // Boot from reset, then three back-to-back fetches acked in their first WAIT cycle.
        tbl[0] = '{1, 0, 32'h0,  0, 2'b00, 32'h0,   0, 32'h0,   0, 32'h0,  32'h0};
        tbl[1] = '{1, 0, 32'h0,  0, 2'b00, 32'h0,   0, 32'h0,   0, 32'h0,  32'h0};
        tbl[2] = '{0, 0, 32'h0,  1, 2'b01, 32'h100, 0, 32'h0,   0, 32'h0,  32'h0};
        tbl[3] = '{0, 0, 32'h0,  0, 2'b00, 32'h100, 1, 32'h100, 0, 32'h0,  32'h0};
        tbl[4] = '{0, 1, 32'hA0, 1, 2'b10, 32'h101, 0, 32'h100, 1, 32'hA0, 32'h100};
        tbl[5] = '{0, 0, 32'h0,  0, 2'b00, 32'h101, 1, 32'h101, 0, 32'hA0, 32'h100};
        tbl[6] = '{0, 1, 32'hA1, 1, 2'b10, 32'h102, 0, 32'h101, 1, 32'hA1, 32'h101};
        tbl[7] = '{0, 0, 32'h0,  0, 2'b00, 32'h102, 1, 32'h102, 0, 32'hA1, 32'h101};
        tbl[8] = '{0, 1, 32'hA2, 1, 2'b10, 32'h103, 0, 32'h102, 1, 32'hA2, 32'h102};

        for (int i = 0; i < 9; i++) begin
            rst        = tbl[i].rst;
            imem_ack   = tbl[i].ack;
            imem_rdata = tbl[i].rdata;
            cycle();
            if (!tbl[i].rst) chk("tbl_pc_en", s_en, tbl[i].e_en);
            if (tbl[i].e_en) chk("tbl_pc_sel", s_sel, tbl[i].e_sel);
            chk("tbl_pc_q", pc_q, tbl[i].e_pc);
            chk("tbl_imem_req", imem_req, tbl[i].e_req);
            chk("tbl_imem_addr", imem_addr, tbl[i].e_addr);
            chk("tbl_instr_valid", instr_valid, tbl[i].e_valid);
            if (tbl[i].e_valid) begin
                chk("tbl_instr_out", instr_out, tbl[i].e_instr);
                chk("tbl_instr_pc", instr_pc, tbl[i].e_ipc);
            end
        end
        imem_ack = 0;

        // Killed fetch: branch while waiting, ack arrives three cycles later
        cycle();
        branch_taken = 1; br_target = 32'h200;
        cycle();
        branch_taken = 0;
        cycle();
        cycle();
        imem_ack = 1; imem_rdata = 32'hDEAD_BEEF;
        cycle();
        imem_ack = 0;
        chk("kill_no_valid", instr_valid, 1'b0);
        cycle();
        chk("kill_redirect_req", imem_req, 1'b1);
        chk("kill_redirect_addr", imem_addr, 32'h200);
        imem_ack = 1; imem_rdata = 32'h1234;
        cycle();
        imem_ack = 0;
        chk("kill_next_valid", instr_valid, 1'b1);
        chk("kill_next_pc", instr_pc, 32'h200);

        // Interrupt raised while a fetch at 0x105 is outstanding
        branch_taken = 1; br_target = 32'h105;
        cycle();
        branch_taken = 0;
        cycle();
        intr_req = 1;
        cycle();
        imem_ack = 1; imem_rdata = 32'h55;
        cycle();
        imem_ack = 0;
        chk("intr_defer_valid", instr_valid, 1'b1);
        chk("intr_defer_pc", instr_pc, 32'h105);
        cycle();
        chk("intr_pc_en", s_en, INTR_EN);
        chk("intr_ack_pulse", intr_ack, INTR_EN);
        chk("intr_epc", epc, INTR_EN ? 32'h106 : 32'h0);
        intr_req = 0; stall = 1; imem_ack = 1;
        cycle();
        imem_ack = 0;

        // Stall held in IDLE for four cycles
        p0 = m_pc;
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk("stall_req_low", imem_req, 1'b0);
            chk("stall_pc_hold", pc_q, p0);
        end
        stall = 0;
        cycle();
        chk("stall_release_req", imem_req, 1'b1);
        chk("stall_release_addr", imem_addr, p0);
        imem_ack = 1;
        cycle();
        imem_ack = 0;

        // Sequential address wraps at the top of the address space
        branch_taken = 1; br_target = 32'hFFFF_FFFF;
        cycle();
        branch_taken = 0;
        chk("wrap_next_addr", next_addr, 32'h0);
        cycle();
        imem_ack = 1;
        cycle();
        imem_ack = 0;
        chk("wrap_pc", pc_q, 32'h0);

        // Reset while a request is outstanding, followed by stray acks
        cycle();
        chk("rstw_req_before", imem_req, 1'b1);
        rst = 1;
        cycle();
        rst = 0;
        chk("rstw_req_dropped", imem_req, 1'b0);
        imem_ack = 1;
        cycle();
        chk("rstw_boot_en", s_en, 1'b1);
        chk("rstw_boot_sel", s_sel, 2'b01);
        chk("rstw_stray_valid", instr_valid, 1'b0);
        stall = 1;
        cycle();
        chk("rstw_stray_valid2", instr_valid, 1'b0);
        stall = 0; imem_ack = 0;

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            rst          = ($urandom_range(0, 99) == 0);
            branch_taken = ($urandom_range(0, 5) == 0);
            stall        = ($urandom_range(0, 3) == 0);
            intr_req     = ($urandom_range(0, 7) == 0);
            imem_ack     = ($urandom_range(0, 1) == 1);
            imem_rdata   = $urandom;
            br_target    = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFF : $urandom;
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
